// File: rtl/deser_8b_32b_pkg.sv
// Shared PHY definitions for the 8b<->32b lane (de)serializers.
// Both ends use BYTES_PER_WORD and the byte-index constants so that the
// byte count and byte ordering of a word always agree across the link.
package deser_8b_32b_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] BYTE0 = 2'd0;
    localparam logic [1:0] BYTE1 = 2'd1;
    localparam logic [1:0] BYTE2 = 2'd2;
    localparam logic [1:0] BYTE3 = 2'(BYTES_PER_WORD - 1);

    // Write byte b into accumulator slot idx; slot 0 is the first (oldest)
    // byte and sits in the top bits so {acc, last_byte} is in arrival order.
    function automatic logic [23:0] acc_store(input logic [23:0] acc,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
        logic [23:0] r;
        r = acc;
        case (idx)
            BYTE0:   r[23:16] = b;
            BYTE1:   r[15:8]  = b;
            BYTE2:   r[7:0]   = b;
            default: r        = acc;
        endcase
        return r;
    endfunction

    // Reverse byte order of a 32-bit word.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/deser_8b_32b.sv
// Receive-side byte-to-word assembler: collects four consecutive valid
// bytes and presents them as one registered 32-bit word. Any gap in
// valid_in restarts alignment at byte 0; a gap inside a word is flagged
// on partial_err.
module deser_8b_32b
    import deser_8b_32b_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic [31:0]      data_8_32,
    output logic             valid_8_32,
    output logic             word_stb,
    output logic             partial_err,
    output logic [CNT_W-1:0] word_cnt
);

    state_t             state, state_nxt;
    logic [1:0]         sel, sel_nxt;
    logic [23:0]        acc, acc_nxt;
    logic [31:0]        data_nxt;
    logic               valid_nxt, stb_nxt, perr_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [31:0]        word_in_order;
    logic [31:0]        word;

    assign word_in_order = {acc, data_in};
    assign word          = MSB_FIRST ? word_in_order : byte_swap32(word_in_order);

    // State register.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: any valid byte enters/stays in COLLECT, any gap returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (valid_in)  state_nxt = ST_COLLECT;
            ST_COLLECT: if (!valid_in) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        sel_nxt   = sel;
        acc_nxt   = acc;
        data_nxt  = data_8_32;
        valid_nxt = valid_8_32;
        stb_nxt   = 1'b0;
        perr_nxt  = 1'b0;
        cnt_nxt   = word_cnt;
        case (state)
            ST_IDLE: begin
                valid_nxt = 1'b0;
                if (valid_in) begin
                    acc_nxt = acc_store(acc, BYTE0, data_in);
                    sel_nxt = BYTE1;
                end
            end
            ST_COLLECT: begin
                if (valid_in) begin
                    if (sel == BYTE3) begin
                        data_nxt  = word;
                        stb_nxt   = 1'b1;
                        valid_nxt = 1'b1;
                        sel_nxt   = BYTE0;
                        if (word_cnt != {CNT_W{1'b1}})
                            cnt_nxt = word_cnt + CNT_W'(1);
                    end else begin
                        acc_nxt = acc_store(acc, sel, data_in);
                        sel_nxt = sel + 2'd1;
                    end
                end else begin
                    // Stream stopped: drop valid like the transmitter does;
                    // only a stop inside a word is an error.
                    valid_nxt = 1'b0;
                    sel_nxt   = BYTE0;
                    if (sel != BYTE0) begin
                        perr_nxt = 1'b1;
                        acc_nxt  = '0;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                sel_nxt   = BYTE0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            sel         <= BYTE0;
            acc         <= '0;
            data_8_32   <= '0;
            valid_8_32  <= 1'b0;
            word_stb    <= 1'b0;
            partial_err <= 1'b0;
            word_cnt    <= '0;
        end else begin
            sel         <= sel_nxt;
            acc         <= acc_nxt;
            data_8_32   <= data_nxt;
            valid_8_32  <= valid_nxt;
            word_stb    <= stb_nxt;
            partial_err <= perr_nxt;
            word_cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_deser_8b_32b.sv
// Bench for deser_8b_32b: one MSB-first instance with a wide counter and
// one LSB-first instance with a 2-bit counter (to reach saturation) share
// the same byte stream.
module tb_deser_8b_32b;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;

    logic [31:0] data0, data1;
    logic        vld0, vld1, stb0, stb1, perr0, perr1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    deser_8b_32b #(.MSB_FIRST(1'b1), .CNT_W(16)) dut0 (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_8_32(data0), .valid_8_32(vld0), .word_stb(stb0),
        .partial_err(perr0), .word_cnt(cnt0)
    );

    deser_8b_32b #(.MSB_FIRST(1'b0), .CNT_W(2)) dut1 (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_8_32(data1), .valid_8_32(vld1), .word_stb(stb1),
        .partial_err(perr1), .word_cnt(cnt1)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       stb;
        logic       perr;
        logic       vld;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model state
    logic [7:0]  m_b0, m_b1, m_b2;
    int          m_sel  = 0;
    logic [31:0] m_last = '0;
    int          m_cnt  = 0;

    function automatic vec_t mk(logic v, logic [7:0] d, logic stb, logic perr, logic vld);
        vec_t r;
        r.v = v; r.d = d; r.stb = stb; r.perr = perr; r.vld = vld;
        return r;
    endfunction

    function automatic logic [31:0] rev(logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sel  = 0;
        m_last = '0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    // Drive one byte-cycle, advance the model, then check the running state.
    task automatic step(logic v, logic [7:0] d);
        logic [31:0] w;
        @(negedge clk_4f);
        valid_in = v;
        data_in  = d;
        if (v) begin
            case (m_sel)
                0: m_b0 = d;
                1: m_b1 = d;
                2: m_b2 = d;
                default: ;
            endcase
            if (m_sel == 3) begin
                w = {m_b0, m_b1, m_b2, d};
                exp_q.push_back(w);
                m_last = w;
                m_cnt++;
                m_sel = 0;
            end else begin
                m_sel++;
            end
        end else begin
            m_sel = 0;
        end
        @(posedge clk_4f);
        #1;
        if (stb0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got word %h want none", data0);
            end else begin
                w = exp_q.pop_front();
                chk("sb_word", data0, w);
            end
        end
        chk("data0", data0, m_last);
        chk("data1", data1, rev(m_last));
        chk("cnt0", 32'(cnt0), 32'(m_cnt));
        chk("cnt1", 32'(cnt1), 32'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic chk_zero(string name);
        chk({name, "_data0"}, data0, 32'h0);
        chk({name, "_data1"}, data1, 32'h0);
        chk({name, "_flags"}, {26'h0, vld0, vld1, stb0, stb1, perr0, perr1}, 32'h0);
        chk({name, "_cnt"}, {14'h0, cnt0, cnt1}, 32'h0);
    endtask

    initial begin
        // Reference vectors: {valid, byte, exp word_stb, exp partial_err, exp valid_8_32}
        vecs.push_back(mk(1, 8'hDE, 0, 0, 0));
        vecs.push_back(mk(1, 8'hAD, 0, 0, 0));
        vecs.push_back(mk(1, 8'hBE, 0, 0, 0));
        vecs.push_back(mk(1, 8'hEF, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0));
        vecs.push_back(mk(1, 8'h02, 0, 0, 0));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0));
        vecs.push_back(mk(1, 8'h04, 1, 0, 1));
        vecs.push_back(mk(1, 8'h05, 0, 0, 1));
        vecs.push_back(mk(1, 8'h06, 0, 0, 1));
        vecs.push_back(mk(1, 8'h07, 0, 0, 1));
        vecs.push_back(mk(1, 8'h08, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 0));
        vecs.push_back(mk(1, 8'hBB, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, 8'h44, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0));

        // Reset held low with random stimulus
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_4f);
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            @(posedge clk_4f);
            #1;
            chk_zero("reset_hold");
        end
        @(negedge clk_4f);
        valid_in = 1'b0;
        reset    = 1'b1;
        model_reset();

        // Table-driven main sequences
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d);
            chk($sformatf("v%0d_stb0", i),  32'(stb0),  32'(vecs[i].stb));
            chk($sformatf("v%0d_stb1", i),  32'(stb1),  32'(vecs[i].stb));
            chk($sformatf("v%0d_perr0", i), 32'(perr0), 32'(vecs[i].perr));
            chk($sformatf("v%0d_perr1", i), 32'(perr1), 32'(vecs[i].perr));
            chk($sformatf("v%0d_vld0", i),  32'(vld0),  32'(vecs[i].vld));
            chk($sformatf("v%0d_vld1", i),  32'(vld1),  32'(vecs[i].vld));
            if (i == 3) begin
                chk("deadbeef_msb", data0, 32'hDEADBEEF);
                chk("deadbeef_lsb", data1, 32'hEFBEADDE);
            end
        end
        chk("final_word", data0, 32'h11223344);
        chk("cnt_four", 32'(cnt0), 32'd4);
        chk("cnt_saturated", 32'(cnt1), 32'd3);

        // Reset mid-word: clears asynchronously, no partial_err
        step(1, 8'h5A);
        step(1, 8'hA5);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        @(negedge clk_4f);
        valid_in = 1'b1;
        data_in  = 8'h77;
        @(posedge clk_4f);
        #1;
        chk_zero("reset_edge");
        @(negedge clk_4f);
        valid_in = 1'b0;
        reset    = 1'b1;

        // Fresh burst after reset assembles from byte 0
        step(1, 8'h0A);
        step(1, 8'h0B);
        step(1, 8'h0C);
        chk("post_reset_no_stb", {31'h0, stb0}, 32'h0);
        step(1, 8'h0D);
        chk("post_reset_stb", {31'h0, stb0}, 32'h1);
        chk("post_reset_word", data0, 32'h0A0B0C0D);
        chk("post_reset_word_lsb", data1, 32'h0D0C0B0A);
        chk("post_reset_cnt", 32'(cnt0), 32'd1);
        step(0, 8'h00);
        chk("post_reset_vld_drop", {31'h0, vld0}, 32'h0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
